// File: rtl/reg_file_mp.sv
// Multi-read-port register file with registered reads, hard-wired x0, write-protect mask
// and a pending-write scoreboard. Define REG_FILE_BYPASS_EN for same-cycle write-through on reads.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT = 32,
    parameter int NUM_RD = 2,
    parameter logic [REG_COUNT-1:0] WRITE_MASK = REG_COUNT'(32'h073fc00f),
    localparam int ADDR_W = $clog2(REG_COUNT)
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         wen,
    input  logic [ADDR_W-1:0]            rd,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic [NUM_RD*ADDR_W-1:0]     rs_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    input  logic                         rsv_en,
    input  logic [ADDR_W-1:0]            rsv_addr,
    output logic [NUM_RD-1:0]            rs_busy,
    output logic [REG_COUNT-1:0]         busy_vec
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:0]  busy;
    logic [REG_COUNT-1:0]  busy_next;
    logic [ADDR_W-1:0]     rs_a [NUM_RD];
    logic [DATA_WIDTH-1:0] rd_next [NUM_RD];
    logic                  write_ok;
    logic                  rsv_ok;
    logic                  clr_ok;

    assign write_ok = wen && (rd != '0) && WRITE_MASK[rd];
    assign rsv_ok   = rsv_en && (rsv_addr != '0) && WRITE_MASK[rsv_addr];
    // Clearing ignores the mask so a stale reservation on a protected register can still retire.
    assign clr_ok   = wen && (rd != '0);

    genvar g;
    generate
        for (g = 0; g < NUM_RD; g++) begin : g_port
            assign rs_a[g]    = rs_addr[g*ADDR_W +: ADDR_W];
            assign rs_busy[g] = busy[rs_a[g]] && !(wen && (rd == rs_a[g]));
        end
    endgenerate

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (write_ok) begin
            regs[rd] <= data_in;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_next[i] = (rs_a[i] == '0) ? '0 : regs[rs_a[i]];
`ifdef REG_FILE_BYPASS_EN
            if (write_ok && (rd == rs_a[i])) rd_next[i] = data_in;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rd_data <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) rd_data[i*DATA_WIDTH +: DATA_WIDTH] <= rd_next[i];
        end
    end

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        busy_next = busy;
        if (clr_ok) busy_next[rd] = 1'b0;
        if (rsv_ok) busy_next[rsv_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) busy <= '0;
        else       busy <= busy_next;
    end

    assign busy_vec = busy;

endmodule
